// File: rtl/control_pipe_unit_if.sv
// Control-unit <-> datapath bundle: ID-stage instruction and EX comparator flags in,
// decoded EX control and pipeline steering out.
interface control_pipe_unit_if #(
  parameter int unsigned INST_WIDTH     = 32,
  parameter int unsigned IMM_SEL_WIDTH  = 3,
  parameter int unsigned ALU_SEL_WIDTH  = 4,
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic                      id_valid;
  logic [INST_WIDTH-1:0]     id_inst;
  logic                      br_eq;
  logic                      br_lt;
  logic [IMM_SEL_WIDTH-1:0]  imm_sel;
  logic                      id_stall;
  logic                      if_flush;
  logic                      pc_sel;
  logic                      ex_valid;
  logic                      ex_reg_write_en;
  logic                      ex_mem_write;
  logic                      ex_mem_read;
  logic                      ex_asel;
  logic                      ex_bsel;
  logic                      ex_br_un;
  logic [ALU_SEL_WIDTH-1:0]  ex_alu_sel;
  logic [1:0]                ex_wb_sel;
  logic [2:0]                ex_funct3;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      mul_busy;
  logic                      illegal_inst;

  modport master (
    output id_valid, id_inst, br_eq, br_lt,
    input  imm_sel, id_stall, if_flush, pc_sel, ex_valid, ex_reg_write_en,
           ex_mem_write, ex_mem_read, ex_asel, ex_bsel, ex_br_un, ex_alu_sel,
           ex_wb_sel, ex_funct3, ex_rd, mul_busy, illegal_inst
  );

  modport slave (
    input  id_valid, id_inst, br_eq, br_lt,
    output imm_sel, id_stall, if_flush, pc_sel, ex_valid, ex_reg_write_en,
           ex_mem_write, ex_mem_read, ex_asel, ex_bsel, ex_br_un, ex_alu_sel,
           ex_wb_sel, ex_funct3, ex_rd, mul_busy, illegal_inst
  );
endinterface

// File: rtl/control_pipe_unit.sv
// Pipelined RV32I(+M) control: ID decode into an ID/EX control register, EX branch
// resolution, load-use interlock and a multi-cycle M-op stall FSM.
module control_pipe_unit #(
  parameter int unsigned INST_WIDTH     = 32,
  parameter int unsigned IMM_SEL_WIDTH  = 3,
  parameter int unsigned ALU_SEL_WIDTH  = 4,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MUL_EN         = 1,
  parameter int unsigned MUL_LATENCY    = 4
) (
  input  logic               clk,
  input  logic               reset,
  control_pipe_unit_if.slave bus
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_R = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5
  } imm_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_XOR = 4'd2, ALU_OR = 4'd3,
    ALU_AND = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_PASS_B = 4'd10, ALU_MEXT = 4'd11
  } alu_e;

  typedef enum logic [1:0] {WB_MEM = 2'b00, WB_ALU = 2'b01, WB_PC4 = 2'b10} wb_e;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} mstate_e;

  typedef struct packed {
    logic                      valid;
    logic                      reg_write_en;
    logic                      mem_write;
    logic                      mem_read;
    logic                      asel;
    logic                      bsel;
    logic                      br_un;
    logic                      branch;
    logic                      jump;
    logic [ALU_SEL_WIDTH-1:0]  alu_sel;
    logic [1:0]                wb_sel;
    logic [2:0]                funct3;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } ex_ctrl_t;

  // BUSY covers all but the final EX cycle of an M op; that last cycle runs in IDLE
  // without stalling, so the op sits in EX for exactly MUL_LATENCY cycles.
  localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 2);

  function automatic alu_e alu_decode(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [INST_WIDTH-1:0]     inst;
  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [6:0]                funct7;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;

  ex_ctrl_t dec;
  imm_e     imm_kind;
  logic     dec_illegal;
  logic     dec_mext;
  logic     use_rs1;
  logic     use_rs2;

  ex_ctrl_t ex_q, ex_d;
  logic     illegal_inst_q, illegal_inst_d;
  mstate_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic busy;
  logic br_cond;
  logic taken;
  logic load_use;

  assign inst   = bus.id_inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rs1    = REG_ADDR_WIDTH'(inst[19:15]);
  assign rs2    = REG_ADDR_WIDTH'(inst[24:20]);

  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.funct3  = funct3;
    dec.rd      = REG_ADDR_WIDTH'(inst[11:7]);
    dec.alu_sel = ALU_SEL_WIDTH'(ALU_ADD);
    dec.wb_sel  = WB_ALU;
    imm_kind    = IMM_R;
    dec_illegal = 1'b0;
    dec_mext    = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1          = 1'b1;
        use_rs2          = 1'b1;
        dec.reg_write_en = 1'b1;
        if (funct7 == 7'b0000001) begin
          if (MUL_EN != 0) begin
            dec_mext    = 1'b1;
            dec.alu_sel = ALU_SEL_WIDTH'(ALU_MEXT);
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          dec.alu_sel = ALU_SEL_WIDTH'(alu_decode(funct3, inst[30], 1'b1));
        end
      end
      OPC_OPIMM: begin
        imm_kind         = IMM_I;
        use_rs1          = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.bsel         = 1'b1;
        dec.alu_sel      = ALU_SEL_WIDTH'(alu_decode(funct3, inst[30], 1'b0));
      end
      OPC_LOAD: begin
        imm_kind         = IMM_I;
        use_rs1          = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.mem_read     = 1'b1;
        dec.bsel         = 1'b1;
        dec.wb_sel       = WB_MEM;
      end
      OPC_STORE: begin
        imm_kind      = IMM_S;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.mem_write = 1'b1;
        dec.bsel      = 1'b1;
      end
      OPC_BRANCH: begin
        imm_kind    = IMM_B;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        dec.branch  = 1'b1;
        dec.asel    = 1'b1;
        dec.bsel    = 1'b1;
        dec.br_un   = funct3[1];
        dec_illegal = (funct3[2:1] == 2'b01);
      end
      OPC_JAL: begin
        imm_kind         = IMM_J;
        dec.jump         = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.asel         = 1'b1;
        dec.bsel         = 1'b1;
        dec.wb_sel       = WB_PC4;
      end
      OPC_JALR: begin
        imm_kind         = IMM_I;
        use_rs1          = 1'b1;
        dec.jump         = 1'b1;
        dec.reg_write_en = 1'b1;
        dec.bsel         = 1'b1;
        dec.wb_sel       = WB_PC4;
      end
      OPC_LUI: begin
        imm_kind         = IMM_U;
        dec.reg_write_en = 1'b1;
        dec.bsel         = 1'b1;
        dec.alu_sel      = ALU_SEL_WIDTH'(ALU_PASS_B);
      end
      OPC_AUIPC: begin
        imm_kind         = IMM_U;
        dec.reg_write_en = 1'b1;
        dec.asel         = 1'b1;
        dec.bsel         = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec.rd == '0) dec.reg_write_en = 1'b0;
  end

  assign busy    = (state_q == ST_BUSY);
  assign br_cond = ex_q.funct3[2] ? (bus.br_lt ^ ex_q.funct3[0]) : (bus.br_eq ^ ex_q.funct3[0]);
  assign taken   = ex_q.valid & (ex_q.jump | (ex_q.branch & br_cond));

  assign load_use = bus.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                    ((use_rs1 & (rs1 == ex_q.rd)) | (use_rs2 & (rs2 == ex_q.rd)));

  always_comb begin
    ex_d           = ex_q;
    illegal_inst_d = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    if (busy) begin
      if (cnt_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (taken || load_use || !bus.id_valid || dec_illegal) begin
      ex_d           = '0;
      illegal_inst_d = bus.id_valid & dec_illegal & ~taken & ~load_use;
    end else begin
      ex_d = dec;
      if (dec_mext) begin
        state_d = ST_BUSY;
        cnt_d   = CNT_LOAD;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q           <= '0;
      illegal_inst_q <= 1'b0;
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
    end else begin
      ex_q           <= ex_d;
      illegal_inst_q <= illegal_inst_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
    end
  end

  assign bus.imm_sel         = IMM_SEL_WIDTH'(imm_kind);
  assign bus.id_stall        = busy | (load_use & ~taken);
  assign bus.if_flush        = taken;
  assign bus.pc_sel          = taken;
  assign bus.ex_valid        = ex_q.valid;
  assign bus.ex_reg_write_en = ex_q.reg_write_en;
  assign bus.ex_mem_write    = ex_q.mem_write;
  assign bus.ex_mem_read     = ex_q.mem_read;
  assign bus.ex_asel         = ex_q.asel;
  assign bus.ex_bsel         = ex_q.bsel;
  assign bus.ex_br_un        = ex_q.br_un;
  assign bus.ex_alu_sel      = ex_q.alu_sel;
  assign bus.ex_wb_sel       = ex_q.wb_sel;
  assign bus.ex_funct3       = ex_q.funct3;
  assign bus.ex_rd           = ex_q.rd;
  assign bus.mul_busy        = busy;
  assign bus.illegal_inst    = illegal_inst_q;

endmodule

// File: tb/tb_control_pipe_unit.sv
// Directed bench for control_pipe_unit: per-cycle expectations are queued by the
// stimulus process and compared by a negedge monitor against two DUT builds.
module tb_control_pipe_unit;

  typedef struct packed {
    logic       ex_valid, rwe, mw, mr, asel, bsel, brun;
    logic [3:0] alu;
    logic [1:0] wb;
    logic [2:0] f3;
    logic [4:0] rd;
    logic       stall, flush, pcsel, busy, ill;
    logic [2:0] imm;
  } obs_t;

  typedef struct packed { obs_t e; obs_t m; } pair_t;

  typedef struct {
    string tag;
    bit    sel;
    obs_t  e;
    obs_t  m;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   n_vec;
  int   n_bad;
  obs_t obs1, obs2;

  control_pipe_unit_if bus1 ();
  control_pipe_unit_if bus2 ();

  control_pipe_unit #(.MUL_EN(1), .MUL_LATENCY(4)) dut (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  control_pipe_unit #(.MUL_EN(0), .MUL_LATENCY(4)) dut_nomul (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb obs1 = {bus1.ex_valid, bus1.ex_reg_write_en, bus1.ex_mem_write, bus1.ex_mem_read,
                      bus1.ex_asel, bus1.ex_bsel, bus1.ex_br_un, bus1.ex_alu_sel, bus1.ex_wb_sel,
                      bus1.ex_funct3, bus1.ex_rd, bus1.id_stall, bus1.if_flush, bus1.pc_sel,
                      bus1.mul_busy, bus1.illegal_inst, bus1.imm_sel};
  always_comb obs2 = {bus2.ex_valid, bus2.ex_reg_write_en, bus2.ex_mem_write, bus2.ex_mem_read,
                      bus2.ex_asel, bus2.ex_bsel, bus2.ex_br_un, bus2.ex_alu_sel, bus2.ex_wb_sel,
                      bus2.ex_funct3, bus2.ex_rd, bus2.id_stall, bus2.if_flush, bus2.pc_sel,
                      bus2.mul_busy, bus2.illegal_inst, bus2.imm_sel};

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t x;
      obs_t a;
      x = sb.pop_front();
      a = x.sel ? obs2 : obs1;
      n_vec++;
      if (((a ^ x.e) & x.m) != '0) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h (care mask %h)", x.tag, a, x.e, x.m);
      end
    end
  end

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2, r1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] btype(input logic [4:0] r2, r1, input logic [2:0] f3);
    return {7'b0, r2, r1, f3, 5'b0, 7'b1100011};
  endfunction

  function automatic pair_t bubble();
    pair_t p;
    p.e = '0;
    p.m = '0;
    p.m.ex_valid = 1'b1;
    p.m.rwe = 1'b1;
    p.m.mw = 1'b1;
    p.m.mr = 1'b1;
    return p;
  endfunction

  function automatic pair_t exv(input logic rwe, mw, mr, asel, bsel, brun, input logic [3:0] alu,
                                input logic [1:0] wb, input logic [2:0] f3, input logic [4:0] rd);
    pair_t p;
    p.e = '0;
    p.m = '0;
    p.e.ex_valid = 1'b1; p.e.rwe = rwe; p.e.mw = mw; p.e.mr = mr;
    p.e.asel = asel; p.e.bsel = bsel; p.e.brun = brun;
    p.e.alu = alu; p.e.wb = wb; p.e.f3 = f3; p.e.rd = rd;
    p.m.ex_valid = 1'b1; p.m.rwe = 1'b1; p.m.mw = 1'b1; p.m.mr = 1'b1;
    p.m.asel = 1'b1; p.m.bsel = 1'b1; p.m.brun = 1'b1;
    p.m.alu = '1; p.m.f3 = '1;
    p.m.wb = rwe ? 2'b11 : 2'b00;
    p.m.rd = (rwe | mr) ? 5'h1F : 5'h00;
    return p;
  endfunction

  task automatic chk(input string tag, input bit sel, input pair_t ex, input logic stall, flush,
                     busy, ill, input logic [2:0] imm);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.e = ex.e;
    x.m = ex.m;
    x.e.stall = stall; x.e.flush = flush; x.e.pcsel = flush;
    x.e.busy = busy; x.e.ill = ill; x.e.imm = imm;
    x.m.stall = 1'b1; x.m.flush = 1'b1; x.m.pcsel = 1'b1;
    x.m.busy = 1'b1; x.m.ill = 1'b1; x.m.imm = 3'b111;
    sb.push_back(x);
  endtask

  task automatic step(input logic v, input logic [31:0] inst, input logic beq, input logic blt);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus1.id_valid = v; bus1.id_inst = inst; bus1.br_eq = beq; bus1.br_lt = blt;
    bus2.id_valid = v; bus2.id_inst = inst; bus2.br_eq = beq; bus2.br_lt = blt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] i_add3, i_sub4, i_lw5, i_add6, i_lw0, i_add6z, i_beq, i_add7, i_bge, i_bltu;
    logic [31:0] i_mul8, i_mul9, i_add10, i_mul11, i_bad, i_jal;
    pair_t bub;

    i_add3  = rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    i_sub4  = rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
    i_lw5   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    i_add6  = rtype(7'h00, 5'd2, 5'd5, 3'b000, 5'd6);
    i_lw0   = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
    i_add6z = rtype(7'h00, 5'd2, 5'd0, 3'b000, 5'd6);
    i_beq   = btype(5'd2, 5'd1, 3'b000);
    i_add7  = rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd7);
    i_bge   = btype(5'd2, 5'd1, 3'b101);
    i_bltu  = btype(5'd2, 5'd1, 3'b110);
    i_mul8  = rtype(7'h01, 5'd2, 5'd1, 3'b000, 5'd8);
    i_mul9  = rtype(7'h01, 5'd4, 5'd3, 3'b000, 5'd9);
    i_add10 = rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd10);
    i_mul11 = rtype(7'h01, 5'd2, 5'd1, 3'b000, 5'd11);
    i_bad   = {20'd0, 5'd5, 7'h7F};
    i_jal   = {20'd0, 5'd1, 7'b1101111};
    bub     = bubble();

    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus1.id_valid = 1'b0; bus1.id_inst = '0; bus1.br_eq = 1'b0; bus1.br_lt = 1'b0;
    bus2.id_valid = 1'b0; bus2.id_inst = '0; bus2.br_eq = 1'b0; bus2.br_lt = 1'b0;

    @(posedge clk); #1;
    chk("reset_state", 0, bub, 0, 0, 0, 0, 3'd0);

    step(1, i_add3, 0, 0);  chk("c0_bubble_after_reset", 0, bub, 0, 0, 0, 0, 3'd0);
    step(1, i_sub4, 0, 0);  chk("c1_ex_add", 0, exv(1,0,0,0,0,0,4'd0,2'b01,3'd0,5'd3), 0, 0, 0, 0, 3'd0);
    step(1, i_lw5, 0, 0);   chk("c2_ex_sub", 0, exv(1,0,0,0,0,0,4'd1,2'b01,3'd0,5'd4), 0, 0, 0, 0, 3'd1);
    step(1, i_add6, 0, 0);  chk("c3_ex_lw_loaduse_stall", 0, exv(1,0,1,0,1,0,4'd0,2'b00,3'd2,5'd5), 1, 0, 0, 0, 3'd0);
    step(1, i_add6, 0, 0);  chk("c4_loaduse_bubble", 0, bub, 0, 0, 0, 0, 3'd0);
    step(1, i_lw0, 0, 0);   chk("c5_ex_add_after_stall", 0, exv(1,0,0,0,0,0,4'd0,2'b01,3'd0,5'd6), 0, 0, 0, 0, 3'd1);
    step(1, i_add6z, 0, 0); chk("c6_lw_x0_no_stall", 0, exv(0,0,1,0,1,0,4'd0,2'b00,3'd2,5'd0), 0, 0, 0, 0, 3'd0);
    step(1, i_beq, 0, 0);   chk("c7_ex_add_x0_src", 0, exv(1,0,0,0,0,0,4'd0,2'b01,3'd0,5'd6), 0, 0, 0, 0, 3'd3);
    step(1, i_add7, 1, 0);  chk("c8_beq_taken_flush", 0, exv(0,0,0,1,1,0,4'd0,2'b00,3'd0,5'd0), 0, 1, 0, 0, 3'd0);
    step(1, i_sub4, 0, 0);  chk("c9_bubble_after_flush", 0, bub, 0, 0, 0, 0, 3'd0);
    step(1, i_bge, 0, 0);   chk("c10_ex_sub", 0, exv(1,0,0,0,0,0,4'd1,2'b01,3'd0,5'd4), 0, 0, 0, 0, 3'd3);
    step(0, 32'd0, 0, 0);   chk("c11_bge_taken", 0, exv(0,0,0,1,1,0,4'd0,2'b00,3'd5,5'd0), 0, 1, 0, 0, 3'd0);
    step(1, i_bltu, 0, 1);  chk("c12_bubble", 0, bub, 0, 0, 0, 0, 3'd3);
    step(0, 32'd0, 0, 0);   chk("c13_bltu_unsigned_not_taken", 0, exv(0,0,0,1,1,1,4'd0,2'b00,3'd6,5'd0), 0, 0, 0, 0, 3'd0);
    step(1, i_lw5, 0, 0);   chk("c14_bubble_idle", 0, bub, 0, 0, 0, 0, 3'd1);
    step(1, i_beq, 0, 0);   chk("c15_ex_lw_no_dep", 0, exv(1,0,1,0,1,0,4'd0,2'b00,3'd2,5'd5), 0, 0, 0, 0, 3'd3);
    step(1, i_add6, 1, 0);  chk("c16_flush_beats_stall", 0, exv(0,0,0,1,1,0,4'd0,2'b00,3'd0,5'd0), 0, 1, 0, 0, 3'd0);
    step(1, i_mul8, 0, 0);  chk("c17_bubble_before_mul", 0, bub, 0, 0, 0, 0, 3'd0);
    step(1, i_mul9, 0, 0);  chk("c18_mul1_cycle1", 0, exv(1,0,0,0,0,0,4'd11,2'b01,3'd0,5'd8), 1, 0, 1, 0, 3'd0);
    step(1, i_mul9, 0, 0);  chk("c19_mul1_cycle2", 0, exv(1,0,0,0,0,0,4'd11,2'b01,3'd0,5'd8), 1, 0, 1, 0, 3'd0);
    step(1, i_mul9, 0, 0);  chk("c20_mul1_cycle3", 0, exv(1,0,0,0,0,0,4'd11,2'b01,3'd0,5'd8), 1, 0, 1, 0, 3'd0);
    step(1, i_mul9, 0, 0);  chk("c21_mul1_cycle4_release", 0, exv(1,0,0,0,0,0,4'd11,2'b01,3'd0,5'd8), 0, 0, 0, 0, 3'd0);
    step(1, i_add10, 0, 0); chk("c22_mul2_cycle1_no_gap", 0, exv(1,0,0,0,0,0,4'd11,2'b01,3'd0,5'd9), 1, 0, 1, 0, 3'd0);
    step(1, i_add10, 0, 0); chk("c23_mul2_cycle2", 0, exv(1,0,0,0,0,0,4'd11,2'b01,3'd0,5'd9), 1, 0, 1, 0, 3'd0);
    step(1, i_add10, 0, 0); chk("c24_mul2_cycle3", 0, exv(1,0,0,0,0,0,4'd11,2'b01,3'd0,5'd9), 1, 0, 1, 0, 3'd0);
    step(1, i_add10, 0, 0); chk("c25_mul2_cycle4_release", 0, exv(1,0,0,0,0,0,4'd11,2'b01,3'd0,5'd9), 0, 0, 0, 0, 3'd0);
    step(1, i_mul11, 0, 0); chk("c26_ex_add_after_muls", 0, exv(1,0,0,0,0,0,4'd0,2'b01,3'd0,5'd10), 0, 0, 0, 0, 3'd0);
    step(1, i_mul11, 0, 0); chk("c27_mul3_busy", 0, exv(1,0,0,0,0,0,4'd11,2'b01,3'd0,5'd11), 1, 0, 1, 0, 3'd0);
    step(0, 32'd0, 0, 0);
    reset = 1'b1;
    chk("c28_reset_mid_busy", 0, bub, 0, 0, 0, 0, 3'd0);
    step(0, 32'd0, 0, 0);   chk("c29_after_reset", 0, bub, 0, 0, 0, 0, 3'd0);
    step(1, i_bad, 0, 0);   chk("c30_illegal_in_id", 0, bub, 0, 0, 0, 0, 3'd0);
    step(0, 32'd0, 0, 0);   chk("c31_illegal_pulse", 0, bub, 0, 0, 0, 1, 3'd0);
    step(1, i_jal, 0, 0);   chk("c32_illegal_pulse_ends", 0, bub, 0, 0, 0, 0, 3'd5);
    step(0, 32'd0, 0, 0);   chk("c33_jal_flush", 0, exv(1,0,0,1,1,0,4'd0,2'b10,3'd0,5'd1), 0, 1, 0, 0, 3'd0);
    step(0, 32'd0, 0, 0);   chk("c34_bubble_after_jal", 0, bub, 0, 0, 0, 0, 3'd0);
    step(1, i_mul8, 0, 0);  chk("c35_nomul_mul_in_id", 1, bub, 0, 0, 0, 0, 3'd0);
    step(0, 32'd0, 0, 0);   chk("c36_nomul_illegal_pulse", 1, bub, 0, 0, 0, 1, 3'd0);
                            chk("c36_mul_en_busy", 0, exv(1,0,0,0,0,0,4'd11,2'b01,3'd0,5'd8), 1, 0, 1, 0, 3'd0);
    step(0, 32'd0, 0, 0);   chk("c37_nomul_pulse_ends", 1, bub, 0, 0, 0, 0, 3'd0);

    repeat (4) step(0, 32'd0, 0, 0);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
